// File: rtl/spmem_req_arb.sv
// Round-robin front-end arbiter for the spMem32 scratchpad: merges client request
// ports into one memory port and routes in-order read responses back via a tag FIFO.
module spmem_req_arb #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 10,
    parameter int MAX_OUTST   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          cli_req_valid,
    output logic [NUM_CLIENTS-1:0]          cli_req_ready,
    input  logic [NUM_CLIENTS-1:0]          cli_req_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   cli_req_addr,
    input  logic [NUM_CLIENTS*32-1:0]       cli_req_wdata,
    output logic [NUM_CLIENTS-1:0]          cli_rsp_valid,
    output logic [31:0]                     cli_rsp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_wr,
    output logic [ADDR_W-1:0]               mem_req_addr,
    output logic [31:0]                     mem_req_wdata,
    input  logic                            mem_rsp_valid,
    input  logic [31:0]                     mem_rsp_rdata,
    output logic [$clog2(MAX_OUTST):0]      outst_cnt,
    output logic                            err_unexp_rsp
);
    localparam int TAG_W = $clog2(NUM_CLIENTS);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [TAG_W-1:0]       winner, cand;
    logic                   winner_found;
    logic [NUM_CLIENTS-1:0] eligible;
    logic                   fifo_full, fifo_empty;
    logic [TAG_W-1:0]       tag_mem [MAX_OUTST];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   xfer, push, pop, unexp;
    logic [TAG_W-1:0]       head_tag;
    logic [NUM_CLIENTS-1:0] rsp_onehot;
    logic [NUM_CLIENTS-1:0] rsp_valid_reg;
    logic [31:0]            rsp_rdata_reg;
    logic                   err_reg;

    // Full is taken from the registered count, so a same-cycle pop never unblocks a read.
    assign fifo_full  = (cnt_reg == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_reg == '0);

    // Nothing is eligible while reset is asserted, so no grant can leak out of reset.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cli
        assign eligible[gi]      = reset && cli_req_valid[gi] && (cli_req_wr[gi] || !fifo_full);
        assign cli_req_ready[gi] = xfer && (winner == TAG_W'(gi));
        assign rsp_onehot[gi]    = (head_tag == TAG_W'(gi));
    end

    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        cand         = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = TAG_W'((int'(rr_ptr_reg) + k) % NUM_CLIENTS);
            if (!winner_found && eligible[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    assign mem_req_valid = winner_found;
    assign mem_req_wr    = cli_req_wr[winner];
    assign mem_req_addr  = cli_req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign mem_req_wdata = cli_req_wdata[int'(winner)*32 +: 32];

    assign xfer     = winner_found && mem_req_ready;
    assign push     = xfer && !mem_req_wr;
    assign pop      = mem_rsp_valid && !fifo_empty;
    assign unexp    = mem_rsp_valid && fifo_empty;
    assign head_tag = tag_mem[rd_ptr_reg];

    // The pointer only advances on an accepted transfer, so a stalled winner keeps the grant.
    assign rr_ptr_next = xfer ? winner : rr_ptr_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_reg    <= TAG_W'(NUM_CLIENTS - 1);
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
                rsp_rdata_reg <= mem_rsp_rdata;
            end
            rsp_valid_reg <= pop ? rsp_onehot : '0;
            if (unexp) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Tag storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= winner;
        end
    end

    assign cli_rsp_valid = rsp_valid_reg;
    assign cli_rsp_rdata = rsp_rdata_reg;
    assign outst_cnt     = cnt_reg;
    assign err_unexp_rsp = err_reg;
endmodule

// File: tb/tb_spmem_req_arb.sv
// Bench for spmem_req_arb: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the arbitration and read-routing rules.
module tb_spmem_req_arb;
    localparam int N  = 2;
    localparam int AW = 10;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    cli_req_valid, cli_req_ready, cli_req_wr, cli_rsp_valid;
    logic [N*AW-1:0] cli_req_addr;
    logic [N*32-1:0] cli_req_wdata;
    logic [31:0]     cli_rsp_rdata;
    logic            mem_req_valid, mem_req_ready, mem_req_wr;
    logic [AW-1:0]   mem_req_addr;
    logic [31:0]     mem_req_wdata;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata;
    logic [CW-1:0]   outst_cnt;
    logic            err_unexp_rsp;

    spmem_req_arb #(.NUM_CLIENTS(N), .ADDR_W(AW), .MAX_OUTST(MO)) dut (
        .clk(clk), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
        .cli_req_wr(cli_req_wr), .cli_req_addr(cli_req_addr), .cli_req_wdata(cli_req_wdata),
        .cli_rsp_valid(cli_rsp_valid), .cli_rsp_rdata(cli_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .outst_cnt(outst_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: last granted client, queue of outstanding read owners.
    int          m_rr;
    int          m_q[$];
    logic [N-1:0] m_rsp_valid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [N-1:0] last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner();
        for (int k = 1; k <= N; k++) begin
            int i = (m_rr + k) % N;
            if (reset && cli_req_valid[i] && (cli_req_wr[i] || m_q.size() < MO)) return i;
        end
        return -1;
    endfunction

    task automatic set_cli(input int i, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [31:0] d);
        cli_req_valid[i]       = v;
        cli_req_wr[i]          = wr;
        cli_req_addr[i*AW +: AW] = a;
        cli_req_wdata[i*32 +: 32] = d;
    endtask

    // One clock: check request-side outputs, advance the model at the edge, check registers.
    task automatic cycle();
        int w;
        logic xfer;
        logic [N-1:0] exp_ready;
        #1;
        w = m_winner();
        xfer = (w >= 0) && mem_req_ready;
        exp_ready = xfer ? N'(1 << w) : '0;
        check("mem_req_valid", 64'(mem_req_valid), 64'(w >= 0));
        check("cli_req_ready", 64'(cli_req_ready), 64'(exp_ready));
        if (w >= 0) begin
            check("mem_req_wr",    64'(mem_req_wr),    64'(cli_req_wr[w]));
            check("mem_req_addr",  64'(mem_req_addr),  64'(cli_req_addr[w*AW +: AW]));
            check("mem_req_wdata", 64'(mem_req_wdata), 64'(cli_req_wdata[w*32 +: 32]));
        end
        last_ready = cli_req_ready;
        @(posedge clk);
        if (!reset) begin
            m_rr = N - 1;
            m_q.delete();
            m_rsp_valid = '0;
            m_rdata = '0;
            m_err = 1'b0;
        end else begin
            m_rsp_valid = '0;
            if (mem_rsp_valid) begin
                if (m_q.size() > 0) begin
                    m_rsp_valid = N'(1 << m_q.pop_front());
                    m_rdata = mem_rsp_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (xfer) begin
                m_rr = w;
                if (!cli_req_wr[w]) m_q.push_back(w);
            end
        end
        #1;
        check("outst_cnt",     64'(outst_cnt),     64'(m_q.size()));
        check("cli_rsp_valid", 64'(cli_rsp_valid), 64'(m_rsp_valid));
        check("cli_rsp_rdata", 64'(cli_rsp_rdata), 64'(m_rdata));
        check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));
        @(negedge clk);
    endtask

    logic [N-1:0] grant_seq [4];

    initial begin
        m_rr = N - 1;
        m_rsp_valid = '0;
        m_rdata = '0;
        m_err = 1'b0;
        cli_req_valid = '0; cli_req_wr = '0; cli_req_addr = '0; cli_req_wdata = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

        // Reset with both clients requesting.
        reset = 1'b0;
        set_cli(0, 1'b1, 1'b1, 10'h001, 32'h1111_0000);
        set_cli(1, 1'b1, 1'b1, 10'h101, 32'h2222_0000);
        cycle();
        check("rst_ready", 64'(last_ready), 64'd0);
        cycle();
        check("rst_outst", 64'(outst_cnt), 64'd0);
        check("rst_rsp_valid", 64'(cli_rsp_valid), 64'd0);

        // Continuous writes from both clients alternate starting with client 0.
        reset = 1'b1;
        grant_seq[0] = 2'b01; grant_seq[1] = 2'b10; grant_seq[2] = 2'b01; grant_seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_grant", 64'(last_ready), 64'(grant_seq[i]));
        end

        // Client 1 read at 0x12, response three cycles later.
        set_cli(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_cli(1, 1'b1, 1'b0, 10'h012, 32'h0);
        cycle();
        check("rd1_outst", 64'(outst_cnt), 64'd1);
        set_cli(1, 1'b0, 1'b0, 10'h012, 32'h0);
        cycle();
        cycle();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
        cycle();
        mem_rsp_valid = 1'b0;
        check("rd1_rsp_valid", 64'(cli_rsp_valid), 64'h2);
        check("rd1_rdata", 64'(cli_rsp_rdata), 64'hDEAD_BEEF);
        check("rd1_outst_after", 64'(outst_cnt), 64'd0);
        cycle();

        // Four reads fill the tag FIFO; a fifth read stalls while a write still goes.
        for (int i = 0; i < 4; i++) begin
            set_cli(0, 1'b1, 1'b0, AW'(10'h040 + i), 32'h0);
            cycle();
        end
        check("full_outst", 64'(outst_cnt), 64'd4);
        set_cli(1, 1'b1, 1'b1, 10'h3A0, 32'hCAFE_0001);
        cycle();
        check("full_write_grant", 64'(last_ready), 64'h2);
        check("full_outst_hold", 64'(outst_cnt), 64'd4);
        set_cli(0, 1'b0, 1'b0, 10'h0, 32'h0);
        set_cli(1, 1'b0, 1'b1, 10'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5000_0000 + 32'(i);
            cycle();
        end
        mem_rsp_valid = 1'b0;

        // Back-to-back reads from clients 0 and 1, responses routed in order.
        set_cli(0, 1'b1, 1'b0, 10'h0AA, 32'h0);
        cycle();
        set_cli(0, 1'b0, 1'b0, 10'h0AA, 32'h0);
        set_cli(1, 1'b1, 1'b0, 10'h0BB, 32'h0);
        cycle();
        set_cli(1, 1'b0, 1'b0, 10'h0BB, 32'h0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA_0001;
        cycle();
        check("b2b_rsp_a", 64'(cli_rsp_valid), 64'h1);
        check("b2b_data_a", 64'(cli_rsp_rdata), 64'hAAAA_0001);
        mem_rsp_rdata = 32'hBBBB_0002;
        cycle();
        mem_rsp_valid = 1'b0;
        check("b2b_rsp_b", 64'(cli_rsp_valid), 64'h2);
        check("b2b_data_b", 64'(cli_rsp_rdata), 64'hBBBB_0002);

        // Unexpected response with nothing outstanding.
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
        cycle();
        mem_rsp_valid = 1'b0;
        check("unexp_rsp_valid", 64'(cli_rsp_valid), 64'd0);
        check("unexp_err", 64'(err_unexp_rsp), 64'd1);
        cycle();
        cycle();
        check("unexp_err_sticky", 64'(err_unexp_rsp), 64'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("unexp_err_cleared", 64'(err_unexp_rsp), 64'd0);

        // Random traffic with stalls and occasional resets.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                set_cli(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                        AW'($urandom), $urandom);
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rsp_rdata = $urandom;
            cycle();
        end

        // Reset with reads in flight: the late response is flagged.
        reset = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        set_cli(0, 1'b0, 1'b0, 10'h0, 32'h0);
        set_cli(1, 1'b0, 1'b0, 10'h0, 32'h0);
        cycle();
        set_cli(0, 1'b1, 1'b0, 10'h0C0, 32'h0);
        cycle();
        cycle();
        set_cli(0, 1'b0, 1'b0, 10'h0C0, 32'h0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("midrst_outst", 64'(outst_cnt), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1A7E_0000;
        cycle();
        mem_rsp_valid = 1'b0;
        check("midrst_late_err", 64'(err_unexp_rsp), 64'd1);
        check("midrst_no_rsp", 64'(cli_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
